// File: rtl/task_dispatcher.sv
// Pops earliest-deadline tasks from the ready queue, runs them on the tick time-base, drives queue aging.
// Latency: q_rd to busy 2 cycles, tick to done/miss/q_subtract 1 cycle; pops stall while aging is active.
module task_dispatcher #(
    parameter int W             = 42,
    parameter int REPAIR_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         q_empty,
    input  logic [W-2:0] q_data,
    input  logic         q_fail,
    input  logic [W-2:0] q_data_fail,
    output logic         q_rd,
    output logic         q_subtract,
    output logic         q_repair,
    output logic         busy,
    output logic [7:0]   run_id,
    output logic         done,
    output logic [7:0]   done_id,
    output logic         miss,
    output logic [7:0]   miss_id,
    output logic         q_fail_seen,
    output logic [15:0]  miss_count,
    output logic         tick_overrun
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, RUN} state_t;

    localparam int CW = (REPAIR_CYCLES > 1) ? $clog2(REPAIR_CYCLES) : 1;
    localparam logic [CW-1:0] REP_LAST = CW'(REPAIR_CYCLES - 1);

    state_t        state, state_n;
    logic [15:0]   rem, slack;
    logic          flag_r;
    logic          pending;
    logic [CW-1:0] rep_cnt;

    logic          rd_n, busy_n, done_n, miss_n, load, step;
    logic [7:0]    run_id_n, done_id_n, miss_id_n;

    logic [7:0]    hd_id;
    logic [15:0]   hd_dl, hd_ex;
    logic          last_rep, aging_free, aging_idle;
    logic [16:0]   mc_sum;
    logic          unused_bits;

    assign hd_id = q_data[W-2 -: 8];
    assign hd_dl = q_data[W-10 -: 16];
    assign hd_ex = q_data[W-26 -: 16];

    // The failed word is only counted here; its contents belong to a later stage.
    assign unused_bits = ^{q_data_fail, flag_r};

    assign last_rep   = q_repair && (rep_cnt == REP_LAST);
    assign aging_free = !(q_subtract || q_repair) || last_rep;
    // A tick this cycle would raise q_subtract during FETCH, so it also blocks a pop.
    assign aging_idle = !q_subtract && !q_repair && !pending && !tick;

    always_comb begin
        state_n   = state;
        rd_n      = 1'b0;
        busy_n    = busy;
        run_id_n  = run_id;
        done_n    = 1'b0;
        done_id_n = done_id;
        miss_n    = 1'b0;
        miss_id_n = miss_id;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty && aging_idle) begin
                    state_n = FETCH;
                    rd_n    = 1'b1;
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                load = 1'b1;
                if (hd_ex == 16'd0) begin
                    done_n    = 1'b1;
                    done_id_n = hd_id;
                    state_n   = IDLE;
                end else begin
                    busy_n   = 1'b1;
                    run_id_n = hd_id;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    step = 1'b1;
                    if (rem == 16'd1) begin
                        done_n    = 1'b1;
                        done_id_n = run_id;
                        busy_n    = 1'b0;
                        run_id_n  = 8'd0;
                        state_n   = IDLE;
                    end else if (slack <= 16'd1) begin
                        miss_n    = 1'b1;
                        miss_id_n = run_id;
                        busy_n    = 1'b0;
                        run_id_n  = 8'd0;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q_rd    <= 1'b0;
            busy    <= 1'b0;
            run_id  <= 8'd0;
            done    <= 1'b0;
            done_id <= 8'd0;
            miss    <= 1'b0;
            miss_id <= 8'd0;
            rem     <= 16'd0;
            slack   <= 16'd0;
            flag_r  <= 1'b0;
        end else begin
            state   <= state_n;
            q_rd    <= rd_n;
            busy    <= busy_n;
            run_id  <= run_id_n;
            done    <= done_n;
            done_id <= done_id_n;
            miss    <= miss_n;
            miss_id <= miss_id_n;
            if (load) begin
                rem    <= hd_ex;
                slack  <= hd_dl;
                flag_r <= q_data[0];
            end else if (step) begin
                rem   <= (rem   != 16'd0) ? rem   - 16'd1 : 16'd0;
                slack <= (slack != 16'd0) ? slack - 16'd1 : 16'd0;
            end
        end
    end

    // Aging engine: one subtract then a repair window per tick, one tick of look-ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_subtract   <= 1'b0;
            q_repair     <= 1'b0;
            rep_cnt      <= '0;
            pending      <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            q_subtract <= aging_free && (pending || tick);
            if (aging_free) begin
                pending <= pending && tick;
            end else if (tick) begin
                if (pending) tick_overrun <= 1'b1;
                else         pending      <= 1'b1;
            end
            if (q_subtract) begin
                q_repair <= 1'b1;
                rep_cnt  <= '0;
            end else if (last_rep) begin
                q_repair <= 1'b0;
            end else if (q_repair) begin
                rep_cnt <= rep_cnt + CW'(1);
            end
        end
    end

    assign mc_sum = {1'b0, miss_count} + 17'(miss_n) + 17'(q_fail);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_fail_seen <= 1'b0;
            miss_count  <= 16'd0;
        end else begin
            q_fail_seen <= q_fail;
            miss_count  <= mc_sum[16] ? 16'hFFFF : mc_sum[15:0];
        end
    end

endmodule

// File: tb/tb_task_dispatcher.sv
// Scoreboarded bench for task_dispatcher: queue model feeds tasks, expected outcomes are queued on push.
module tb_task_dispatcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        q_empty = 1'b1;
    logic [40:0] q_data = '0;
    logic        q_fail = 1'b0;
    logic [40:0] q_data_fail = '0;
    logic        q_rd, q_subtract, q_repair, busy, done, miss, q_fail_seen, tick_overrun;
    logic [7:0]  run_id, done_id, miss_id;
    logic [15:0] miss_count;

    task_dispatcher #(.W(42), .REPAIR_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .tick(tick), .q_empty(q_empty), .q_data(q_data),
        .q_fail(q_fail), .q_data_fail(q_data_fail), .q_rd(q_rd), .q_subtract(q_subtract),
        .q_repair(q_repair), .busy(busy), .run_id(run_id), .done(done), .done_id(done_id),
        .miss(miss), .miss_id(miss_id), .q_fail_seen(q_fail_seen), .miss_count(miss_count),
        .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_rd = 0, n_sub = 0, n_rep = 0, n_done = 0, n_miss = 0, rd_conflict = 0, rd_cyc = 0;
    int exp_mc = 0;
    logic [40:0] tq[$];
    logic [8:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Queue model and activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (q_rd) begin
            n_rd++;
            rd_cyc = cyc;
            if (tq.size() > 0) q_data = tq.pop_front();
        end
        if (q_rd && (q_subtract || q_repair)) rd_conflict++;
        if (q_subtract) n_sub++;
        if (q_repair) n_rep++;
        if (done) n_done++;
        if (miss) n_miss++;
        q_empty = (tq.size() == 0);
    end

    function automatic logic [40:0] mk(input logic [7:0] id, input logic [15:0] dl, input logic [15:0] ex);
        return {id, dl, ex, 1'b0};
    endfunction

    task automatic push_task(input logic [7:0] id, input logic [15:0] dl, input logic [15:0] ex, input logic kind);
        tq.push_back(mk(id, dl, ex));
        exp_q.push_back({kind, id});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output bit got, output logic kind, output logic [7:0] id, output int at);
        got = 1'b0; kind = 1'b0; id = 8'd0; at = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done || miss) begin
                got = 1'b1; kind = done; id = done ? done_id : miss_id; at = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [47:0] ov;
        rst = 1'b1;
        cycles(3);
        @(negedge clk);
        ov = {q_rd, q_subtract, q_repair, busy, run_id, done, done_id, miss, miss_id,
              q_fail_seen, miss_count, tick_overrun};
        checks++;
        if (ov !== 48'd0) begin failures++; $display("FAIL reset_outputs got=%h want=0", ov); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(2);
        checks++;
        if (q_rd !== 1'b0) begin failures++; $display("FAIL reset_no_pop got=%b want=0", q_rd); end
    endtask

    task automatic test_pop_and_run;
        bit ok;
        logic [8:0] e;
        n_rd = 0; n_sub = 0; n_rep = 0; n_done = 0; n_miss = 0;
        push_task(8'h01, 16'd6, 16'd4, 1'b1);
        wait_busy(ok);
        checks++;
        if (!ok || run_id !== 8'h01) begin failures++; $display("FAIL run_id got=%h busy_ok=%0d want=01", run_id, ok); end
        checks++;
        if (n_rd != 1) begin failures++; $display("FAIL pop_count got=%0d want=1", n_rd); end
        for (int i = 0; i < 3; i++) begin
            pulse_tick;
            cycles(7);
        end
        pulse_tick;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({done, done_id, busy} !== {1'b1, e[7:0], 1'b0} || e[8] !== 1'b1)
            begin failures++; $display("FAIL run_done got=%b/%h/%b want=1/%h/0", done, done_id, busy, e[7:0]); end
        @(posedge clk);
        #1;
        cycles(8);
        checks++;
        if (n_sub != 4 || n_rep != 16) begin failures++; $display("FAIL aging got sub=%0d rep=%0d want 4/16", n_sub, n_rep); end
        checks++;
        if (miss_count !== 16'(exp_mc) || n_done != 1 || n_miss != 0)
            begin failures++; $display("FAIL run_counts got mc=%0d done=%0d miss=%0d want %0d/1/0", miss_count, n_done, n_miss, exp_mc); end
    endtask

    task automatic test_own_miss;
        bit ok;
        logic [8:0] e;
        n_done = 0;
        push_task(8'h05, 16'd2, 16'd4, 1'b0);
        wait_busy(ok);
        pulse_tick;
        cycles(7);
        pulse_tick;
        @(negedge clk);
        e = exp_q.pop_front();
        exp_mc = exp_mc + 1;
        checks++;
        if ({miss, done, miss_id} !== {1'b1, 1'b0, e[7:0]} || e[8] !== 1'b0)
            begin failures++; $display("FAIL own_miss got miss=%b done=%b id=%h want 1/0/%h", miss, done, miss_id, e[7:0]); end
        checks++;
        if (miss_count !== 16'(exp_mc)) begin failures++; $display("FAIL miss_count got=%0d want=%0d", miss_count, exp_mc); end
        @(posedge clk);
        #1;
        cycles(8);
        checks++;
        if (n_done != 0) begin failures++; $display("FAIL miss_no_done got=%0d want=0", n_done); end
    endtask

    task automatic test_zero_exec;
        bit ok, got;
        logic kind;
        logic [7:0] id;
        int at, first_rd;
        logic [8:0] e;
        push_task(8'h07, 16'd0, 16'd0, 1'b1);
        push_task(8'h08, 16'd3, 16'd3, 1'b1);
        wait_result(got, kind, id, at);
        first_rd = rd_cyc;
        e = exp_q.pop_front();
        checks++;
        if (!got || {kind, id} !== e) begin failures++; $display("FAIL zero_exec got=%0d/%b/%h want %h", got, kind, id, e); end
        checks++;
        if (at != first_rd + 2) begin failures++; $display("FAIL zero_exec_lat got=%0d want=%0d", at - first_rd, 2); end
        wait_busy(ok);
        checks++;
        if (!ok || rd_cyc != at + 1 || run_id !== 8'h08)
            begin failures++; $display("FAIL back_to_back got rd_gap=%0d id=%h want 1/08", rd_cyc - at, run_id); end
        pulse_tick;
        cycles(7);
        pulse_tick;
        cycles(7);
        pulse_tick;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({done, miss, done_id} !== {1'b1, 1'b0, e[7:0]} || e[8] !== 1'b1)
            begin failures++; $display("FAIL exec_eq_dl got done=%b miss=%b id=%h want 1/0/%h", done, miss, done_id, e[7:0]); end
        @(posedge clk);
        #1;
        cycles(8);
    endtask

    task automatic test_tick_overrun;
        bit ok;
        logic [8:0] sb, rb, e;
        push_task(8'h09, 16'd40, 16'd5, 1'b1);
        wait_busy(ok);
        cycles(10);
        tick = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            sb[k] = q_subtract;
            rb[k] = q_repair;
            @(posedge clk);
            #1;
            if (k == 2) tick = 1'b0;
        end
        checks++;
        if (sb !== 9'h042) begin failures++; $display("FAIL pending_subtract got=%b want=%b", sb, 9'h042); end
        checks++;
        if (rb !== 9'h1BC) begin failures++; $display("FAIL pending_repair got=%b want=%b", rb, 9'h1BC); end
        checks++;
        if (tick_overrun !== 1'b1) begin failures++; $display("FAIL tick_overrun got=%b want=1", tick_overrun); end
        pulse_tick;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL overrun_early got done=%b busy=%b want 0/1", done, busy); end
        @(posedge clk);
        #1;
        cycles(7);
        pulse_tick;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({done, done_id} !== {1'b1, e[7:0]}) begin failures++; $display("FAIL overrun_done got=%b/%h want 1/%h", done, done_id, e[7:0]); end
        @(posedge clk);
        #1;
        cycles(12);
    endtask

    task automatic test_qfail_miss;
        bit ok;
        int miss_at;
        logic [8:0] e;
        push_task(8'h03, 16'd1, 16'd5, 1'b0);
        wait_busy(ok);
        push_task(8'h04, 16'd10, 16'd1, 1'b1);
        cycles(8);
        tick = 1'b1;
        q_fail = 1'b1;
        q_data_fail = mk(8'h02, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        tick = 1'b0;
        q_fail = 1'b0;
        @(negedge clk);
        miss_at = cyc;
        e = exp_q.pop_front();
        exp_mc = exp_mc + 2;
        checks++;
        if ({miss, q_fail_seen, miss_id} !== {1'b1, 1'b1, e[7:0]})
            begin failures++; $display("FAIL fail_and_miss got miss=%b seen=%b id=%h want 1/1/%h", miss, q_fail_seen, miss_id, e[7:0]); end
        checks++;
        if (miss_count !== 16'(exp_mc)) begin failures++; $display("FAIL miss_count_plus2 got=%0d want=%0d", miss_count, exp_mc); end
        wait_busy(ok);
        checks++;
        if (!ok || rd_cyc != miss_at + 6) begin failures++; $display("FAIL pop_after_repair got gap=%0d want=6", rd_cyc - miss_at); end
        checks++;
        if (rd_conflict != 0) begin failures++; $display("FAIL rd_during_aging got=%0d want=0", rd_conflict); end
        pulse_tick;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({done, done_id} !== {1'b1, e[7:0]}) begin failures++; $display("FAIL after_fail_done got=%b/%h want 1/%h", done, done_id, e[7:0]); end
        @(posedge clk);
        #1;
        cycles(10);
    endtask

    task automatic test_saturation_reset;
        bit ok;
        int n;
        logic [8:0] e;
        logic [47:0] ov;
        n = 65535 - exp_mc + 3;
        q_fail = 1'b1;
        q_data_fail = mk(8'h02, 16'd0, 16'd0);
        repeat (n) @(posedge clk);
        #1;
        q_fail = 1'b0;
        exp_mc = 65535;
        cycles(2);
        checks++;
        if (miss_count !== 16'hFFFF) begin failures++; $display("FAIL saturate got=%h want=ffff", miss_count); end
        push_task(8'h06, 16'd0, 16'd3, 1'b0);
        wait_busy(ok);
        pulse_tick;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({miss, miss_id, miss_count} !== {1'b1, e[7:0], 16'hFFFF})
            begin failures++; $display("FAIL saturate_miss got %b/%h/%h want 1/%h/ffff", miss, miss_id, miss_count, e[7:0]); end
        @(posedge clk);
        #1;
        cycles(10);
        push_task(8'h0A, 16'd50, 16'd9, 1'b1);
        wait_busy(ok);
        pulse_tick;
        cycles(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        exp_mc = 0;
        n_done = 0;
        n_miss = 0;
        @(negedge clk);
        ov = {q_rd, q_subtract, q_repair, busy, run_id, done, done_id, miss, miss_id,
              q_fail_seen, miss_count, tick_overrun};
        checks++;
        if (ov !== 48'd0) begin failures++; $display("FAIL midrun_reset got=%h want=0", ov); end
        @(posedge clk);
        #1;
        push_task(8'h0B, 16'd5, 16'd1, 1'b1);
        wait_busy(ok);
        checks++;
        if (!ok || run_id !== 8'h0B || n_done != 0 || n_miss != 0)
            begin failures++; $display("FAIL repop got id=%h done=%0d miss=%0d want 0b/0/0", run_id, n_done, n_miss); end
        pulse_tick;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({done, done_id, miss_count} !== {1'b1, e[7:0], 16'd0})
            begin failures++; $display("FAIL repop_done got %b/%h/%h want 1/%h/0", done, done_id, miss_count, e[7:0]); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_pop_and_run;
        test_own_miss;
        test_zero_exec;
        test_tick_overrun;
        test_qfail_miss;
        test_saturation_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
